// File: rtl/execute_stage.sv
// Execute stage: operand select, single-cycle ALU, iterative shift-add multiply,
// branch/jump resolution, registered XM outputs. Optional: MUL_EARLY_EXIT_EN.
module execute_stage #(
    parameter int         WIDTH   = 32,
    parameter logic [2:0] NOOP_OP = 3'h1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] pc_value,
    input  logic [WIDTH-1:0] read_data_0,
    input  logic [WIDTH-1:0] read_data_1,
    input  logic [WIDTH-1:0] immediate,
    input  logic [2:0]       alu_op,
    input  logic             alu_src,
    input  logic             branch,
    input  logic             jump,
    input  logic             reg_dst,
    input  logic [4:0]       rt_addr,
    input  logic [4:0]       rd_addr,
    input  logic [3:0]       ctrl_in,
    output logic             stall,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] store_data,
    output logic [4:0]       write_addr,
    output logic [3:0]       ctrl_out,
    output logic             branch_taken,
    output logic [WIDTH-1:0] branch_target
);

    localparam logic [2:0] OP_ADD = 3'h0;
    localparam logic [2:0] OP_SUB = 3'h2;
    localparam logic [2:0] OP_AND = 3'h3;
    localparam logic [2:0] OP_OR  = 3'h4;
    localparam logic [2:0] OP_SLT = 3'h5;
    localparam logic [2:0] OP_MUL = 3'h6;
    localparam logic [2:0] OP_XOR = 3'h7;
    localparam int         CW     = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, next_state;
    logic [WIDTH-1:0]  mcand, mplier, acc;
    logic [CW-1:0]     cnt;

    logic [2:0]        eff_op;
    logic              is_mul;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  alu_c;
    logic [4:0]        wr_addr_c;
    logic [3:0]        ctrl_c;
    logic              redirect_c;
    logic [WIDTH-1:0]  target_c;
    logic              last_step;

    always_comb begin
        eff_op     = in_valid ? alu_op : NOOP_OP;
        is_mul     = (eff_op == OP_MUL);
        op_b       = alu_src ? immediate : read_data_1;
        wr_addr_c  = reg_dst ? rd_addr : rt_addr;
        ctrl_c     = {ctrl_in[3:2], ctrl_in[1] & (wr_addr_c != 5'd0), ctrl_in[0]};
        redirect_c = jump | (branch & (read_data_0 == read_data_1));
        target_c   = jump ? {pc_value[WIDTH-1:28], immediate[25:0], 2'b00}
                          : pc_value + (immediate << 2);
        alu_c      = '0;
        case (eff_op)
            OP_ADD:  alu_c = read_data_0 + op_b;
            OP_SUB:  alu_c = read_data_0 - op_b;
            OP_AND:  alu_c = read_data_0 & op_b;
            OP_OR:   alu_c = read_data_0 | op_b;
            OP_SLT:  alu_c = ($signed(read_data_0) < $signed(op_b)) ? WIDTH'(1) : '0;
            OP_XOR:  alu_c = read_data_0 ^ op_b;
            default: alu_c = '0;
        endcase
    end

`ifdef MUL_EARLY_EXIT_EN
    // Remaining multiplier bits all zero: further steps cannot change acc.
    assign last_step = (cnt == CW'(WIDTH - 1)) || ((mplier >> 1) == '0);
`else
    assign last_step = (cnt == CW'(WIDTH - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (is_mul) next_state = BUSY;
            BUSY:    if (last_step) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Reset forces the stall low even if a MUL is still presented upstream.
    always_comb begin
        stall = ~rst & (((state == IDLE) & is_mul) | (state == BUSY));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == IDLE && is_mul) begin
            mcand  <= read_data_0;
            mplier <= op_b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == BUSY) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            alu_result    <= '0;
            store_data    <= '0;
            write_addr    <= '0;
            ctrl_out      <= '0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else if (state == DONE) begin
            // Product retires with control taken from the still-held MUL inputs.
            out_valid     <= 1'b1;
            alu_result    <= acc;
            store_data    <= read_data_1;
            write_addr    <= wr_addr_c;
            ctrl_out      <= ctrl_c;
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else if (state == BUSY || is_mul || eff_op == NOOP_OP) begin
            out_valid     <= 1'b0;
            alu_result    <= '0;
            store_data    <= '0;
            write_addr    <= '0;
            ctrl_out      <= '0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else begin
            out_valid     <= 1'b1;
            alu_result    <= alu_c;
            store_data    <= read_data_1;
            write_addr    <= wr_addr_c;
            ctrl_out      <= ctrl_c;
            branch_taken  <= redirect_c;
            branch_target <= redirect_c ? target_c : '0;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU ops, write-address rules, MUL timing,
// branch/jump redirects and reset during a multiply.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] pc_value = '0, read_data_0 = '0, read_data_1 = '0, immediate = '0;
    logic [2:0]  alu_op = 3'h1;
    logic        alu_src = 1'b0, branch = 1'b0, jump = 1'b0, reg_dst = 1'b0;
    logic [4:0]  rt_addr = '0, rd_addr = '0;
    logic [3:0]  ctrl_in = '0;
    logic        stall, out_valid, branch_taken;
    logic [31:0] alu_result, store_data, branch_target;
    logic [4:0]  write_addr;
    logic [3:0]  ctrl_out;

    int vectors = 0;
    int miscompares = 0;

    execute_stage #(.WIDTH(32), .NOOP_OP(3'h1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .pc_value(pc_value),
        .read_data_0(read_data_0), .read_data_1(read_data_1), .immediate(immediate),
        .alu_op(alu_op), .alu_src(alu_src), .branch(branch), .jump(jump),
        .reg_dst(reg_dst), .rt_addr(rt_addr), .rd_addr(rd_addr), .ctrl_in(ctrl_in),
        .stall(stall), .out_valid(out_valid), .alu_result(alu_result),
        .store_data(store_data), .write_addr(write_addr), .ctrl_out(ctrl_out),
        .branch_taken(branch_taken), .branch_target(branch_target)
    );

    always #5 clk = ~clk;

`define CHECK(tag, obs, exp) \
    begin \
        vectors++; \
        assert ((obs) === (exp)) else begin \
            miscompares++; \
            $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
        end \
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic src);
        in_valid    = v;
        alu_op      = op;
        read_data_0 = a;
        read_data_1 = b;
        immediate   = imm;
        alu_src     = src;
    endtask

    int stall_cnt, valid_cnt, bubble_bad, edges, done_edge;
    logic [31:0] product;

    initial begin
        #1 rst = 1'b1;
        #1;
        `CHECK("reset_out_valid", out_valid, 1'b0)
        `CHECK("reset_alu_result", alu_result, 32'h0)
        `CHECK("reset_ctrl_out", ctrl_out, 4'h0)
        `CHECK("reset_stall", stall, 1'b0)
        tick();
        tick();
        rst = 1'b0;

        // ADD 5+7, rd selected, reg_write kept
        drive(1'b1, 3'h0, 32'd5, 32'd7, 32'd0, 1'b0);
        reg_dst = 1'b1; rt_addr = 5'd3; rd_addr = 5'd8; ctrl_in = 4'b0010;
        `CHECK("add_stall", stall, 1'b0)
        tick();
        `CHECK("add_result", alu_result, 32'd12)
        `CHECK("add_valid", out_valid, 1'b1)
        `CHECK("add_waddr", write_addr, 5'd8)
        `CHECK("add_ctrl", ctrl_out, 4'b0010)
        `CHECK("add_store", store_data, 32'd7)

        drive(1'b1, 3'h2, 32'd3, 32'd5, 32'd0, 1'b0);
        tick();
        `CHECK("sub_result", alu_result, 32'hFFFF_FFFE)
        drive(1'b1, 3'h5, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        tick();
        `CHECK("slt_result", alu_result, 32'd1)
        drive(1'b1, 3'h5, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        tick();
        `CHECK("slt_false", alu_result, 32'd0)

        drive(1'b1, 3'h3, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0);
        tick();
        `CHECK("and_result", alu_result, 32'h0000_F000)
        alu_op = 3'h4;
        tick();
        `CHECK("or_result", alu_result, 32'h0000_FFF0)
        alu_op = 3'h7;
        tick();
        `CHECK("xor_result", alu_result, 32'h0000_0FF0)

        // immediate operand; write to r0 suppresses reg_write
        drive(1'b1, 3'h0, 32'd10, 32'd99, 32'h20, 1'b1);
        reg_dst = 1'b0; rt_addr = 5'd0; ctrl_in = 4'b0011;
        tick();
        `CHECK("imm_result", alu_result, 32'h2A)
        `CHECK("r0_waddr", write_addr, 5'd0)
        `CHECK("r0_ctrl", ctrl_out, 4'b0001)

        drive(1'b0, 3'h0, 32'd10, 32'd99, 32'h20, 1'b1);
        tick();
        `CHECK("bubble_valid", out_valid, 1'b0)
        `CHECK("bubble_result", alu_result, 32'h0)
        `CHECK("bubble_ctrl", ctrl_out, 4'h0)
        drive(1'b1, 3'h1, 32'd10, 32'd99, 32'h20, 1'b1);
        tick();
        `CHECK("noop_valid", out_valid, 1'b0)

        // MUL 0x1234 * 0x10 held until the product appears
        drive(1'b1, 3'h6, 32'h1234, 32'h10, 32'd0, 1'b0);
        reg_dst = 1'b1; rd_addr = 5'd9; ctrl_in = 4'b0010;
        stall_cnt = 0; valid_cnt = 0; bubble_bad = 0; done_edge = 0; product = '0;
        for (edges = 1; edges <= 40; edges++) begin
            if (stall) stall_cnt++;
            tick();
            if (out_valid) begin
                valid_cnt++;
                product = alu_result;
                if (done_edge == 0) done_edge = edges;
                in_valid = 1'b0;
            end else if (alu_result != 32'h0 || ctrl_out != 4'h0) begin
                bubble_bad++;
            end
        end
        `CHECK("mul_stall_cycles", stall_cnt, 33)
        `CHECK("mul_valid_pulses", valid_cnt, 1)
        `CHECK("mul_product", product, 32'h12340)
        `CHECK("mul_latency", done_edge, 34)
        `CHECK("mul_bubbles", bubble_bad, 0)

        // BEQ taken, then single-cycle pulse, then not-taken
        drive(1'b1, 3'h2, 32'd9, 32'd9, 32'd3, 1'b0);
        branch = 1'b1; pc_value = 32'h100; ctrl_in = 4'b0000;
        tick();
        `CHECK("beq_taken", branch_taken, 1'b1)
        `CHECK("beq_target", branch_target, 32'h10C)
        in_valid = 1'b0;
        tick();
        `CHECK("beq_pulse", branch_taken, 1'b0)
        drive(1'b1, 3'h2, 32'd9, 32'd8, 32'd3, 1'b0);
        tick();
        `CHECK("beq_not_taken", branch_taken, 1'b0)

        // J wins over a simultaneously asserted non-taken branch
        drive(1'b1, 3'h0, 32'd1, 32'd2, 32'h40, 1'b0);
        jump = 1'b1; pc_value = 32'h8000_0004;
        tick();
        `CHECK("jump_taken", branch_taken, 1'b1)
        `CHECK("jump_target", branch_target, 32'h8000_0100)
        jump = 1'b0; branch = 1'b0;

        // reset at BUSY step 10
        drive(1'b1, 3'h6, 32'd3, 32'd5, 32'd0, 1'b0);
        tick();
        repeat (10) tick();
        `CHECK("busy_stall", stall, 1'b1)
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        `CHECK("rst_stall", stall, 1'b0)
        `CHECK("rst_out_valid", out_valid, 1'b0)
        `CHECK("rst_result", alu_result, 32'h0)
        tick();
        rst = 1'b0;
        valid_cnt = 0;
        repeat (40) begin
            tick();
            if (out_valid) valid_cnt++;
        end
        `CHECK("rst_no_product", valid_cnt, 0)
        drive(1'b1, 3'h0, 32'd1, 32'd2, 32'd0, 1'b0);
        tick();
        `CHECK("post_rst_add", alu_result, 32'd3)
        `CHECK("post_rst_valid", out_valid, 1'b1)

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
